// File: rtl/pipe_pkg.sv
// Shared constants for the pipeline stage registers.
//   - Per-boundary control/data widths (IF/ID, ID/EX, EX/MEM, MEM/WB).
//   - Bubble control values: all-zero, so no write, no memory access and no branch.
//   - Control-field bit positions for the ID/EX and EX/MEM control words.
//   - bufState_e: occupancy of a pipe_stage_buf, encoded as {mainValid, skidValid}.
package pipe_pkg;

    localparam int IFID_CTRL_W  = 1;   // predicted-taken flag
    localparam int IFID_DATA_W  = 64;  // PC + instruction
    localparam int IDEX_CTRL_W  = 9;
    localparam int IDEX_DATA_W  = 96;  // rs1, rs2/imm, PC
    localparam int EXMEM_CTRL_W = 5;
    localparam int EXMEM_DATA_W = 102; // branch target, zero, ALU result, store data, rd
    localparam int MEMWB_CTRL_W = 2;
    localparam int MEMWB_DATA_W = 69;  // load data, ALU result, rd

    localparam logic [IFID_CTRL_W-1:0]  IFID_CTRL_BUBBLE  = '0;
    localparam logic [IDEX_CTRL_W-1:0]  IDEX_CTRL_BUBBLE  = '0;
    localparam logic [EXMEM_CTRL_W-1:0] EXMEM_CTRL_BUBBLE = '0;
    localparam logic [MEMWB_CTRL_W-1:0] MEMWB_CTRL_BUBBLE = '0;

    // ID/EX control word layout
    localparam int IDEX_REGDEST_BIT  = 0;
    localparam int IDEX_ALUSRCB_BIT  = 1;
    localparam int IDEX_ALUOP_LSB    = 2; // 2-bit field [3:2]
    localparam int IDEX_MEMREAD_BIT  = 4;
    localparam int IDEX_MEMWRITE_BIT = 5;
    localparam int IDEX_MEMTOREG_BIT = 6;
    localparam int IDEX_REGWRITE_BIT = 7;
    localparam int IDEX_BRANCH_BIT   = 8;

    // EX/MEM control word layout
    localparam int EXMEM_MEMREAD_BIT  = 0;
    localparam int EXMEM_MEMWRITE_BIT = 1;
    localparam int EXMEM_MEMTOREG_BIT = 2;
    localparam int EXMEM_REGWRITE_BIT = 3;
    localparam int EXMEM_BRANCH_BIT   = 4;

    // MEM/WB control word layout
    localparam int MEMWB_MEMTOREG_BIT = 0;
    localparam int MEMWB_REGWRITE_BIT = 1;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_FULL1 = 2'b10,
        ST_FULL2 = 2'b11
    } bufState_e;

endpackage

// File: rtl/pipe_skid_slot.sv
// One storage slot of a stage buffer: valid flag + control word + data word.
// Ports:
//   clk, reset     - clock, asynchronous active-low reset
//   clear          - drop the slot: valid=0, ctrl=CTRL_BUBBLE, data kept
//   load           - capture ldCtrl/ldData and set valid (clear wins)
//   valid/ctrl/data - registered slot contents
module pipe_skid_slot #(
    parameter int                 CTRL_W      = 9,
    parameter int                 DATA_W      = 96,
    parameter logic [CTRL_W-1:0]  CTRL_BUBBLE = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              load,
    input  logic [CTRL_W-1:0] ldCtrl,
    input  logic [DATA_W-1:0] ldData,
    output logic              valid,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] data
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid <= 1'b0;
            ctrl  <= CTRL_BUBBLE;
            data  <= '0;
        end else if (clear) begin
            // Data is left alone on purpose: only the control word has to be safe.
            valid <= 1'b0;
            ctrl  <= CTRL_BUBBLE;
        end else if (load) begin
            valid <= 1'b1;
            ctrl  <= ldCtrl;
            data  <= ldData;
        end
    end

endmodule

// File: rtl/pipe_stage_buf.sv
// Generic pipeline stage register with a valid/ready handshake and a 2-entry
// skid buffer (main slot drives the outputs, skid slot absorbs one beat while
// downstream stalls). Flush squashes both slots and presents a bubble.
// Optional macro PIPE_STAGE_BUF_PERF_EN adds saturating stall/flush counters.
// Ports:
//   clk, reset             - clock, asynchronous active-low reset
//   in_valid/in_ready      - upstream handshake (in_ready is !skidValid, registered)
//   in_ctrl/in_data        - upstream beat
//   flush                  - synchronous squash, overrides all other events
//   out_valid/out_ready    - downstream handshake
//   out_ctrl/out_data      - main slot contents (ctrl = CTRL_BUBBLE when !out_valid)
//   dbgState               - buffer occupancy {mainValid, skidValid}
//   stall_cnt/flush_cnt    - perf counters (PIPE_STAGE_BUF_PERF_EN only)
// Handshake: a beat moves on a rising edge where valid and ready are both high;
// valid never depends combinationally on ready, and outputs come only from flops.
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int                DATA_W      = IDEX_DATA_W,
    parameter int                CTRL_W      = IDEX_CTRL_W,
    parameter logic [CTRL_W-1:0] CTRL_BUBBLE = CTRL_W'(IDEX_CTRL_BUBBLE)
`ifdef PIPE_STAGE_BUF_PERF_EN
    , parameter int              CNT_W       = 16
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        dbgState
`ifdef PIPE_STAGE_BUF_PERF_EN
    , output logic [CNT_W-1:0] stall_cnt
    , output logic [CNT_W-1:0] flush_cnt
`endif
);

    logic              mainValid, skidValid;
    logic [CTRL_W-1:0] mainCtrl, skidCtrl;
    logic [DATA_W-1:0] mainData, skidData;

    logic              mainLoad, mainClear, mainFromSkid;
    logic              skidLoad, skidClear;
    logic [CTRL_W-1:0] mainLdCtrl;
    logic [DATA_W-1:0] mainLdData;
    logic              inXfer, outXfer;
    bufState_e         state;

    assign state   = bufState_e'({mainValid, skidValid});
    assign inXfer  = in_valid && !skidValid;
    assign outXfer = mainValid && out_ready;

    // Next-state decode: translates the occupancy and the two transfers into
    // load/clear strobes for the slots.
    always_comb begin
        mainLoad     = 1'b0;
        mainClear    = 1'b0;
        mainFromSkid = 1'b0;
        skidLoad     = 1'b0;
        skidClear    = 1'b0;
        if (flush) begin
            mainClear = 1'b1;
            skidClear = 1'b1;
        end else begin
            case (state)
                ST_EMPTY: mainLoad = inXfer;
                ST_FULL1: begin
                    if (inXfer && outXfer) mainLoad  = 1'b1;
                    else if (inXfer)       skidLoad  = 1'b1;
                    else if (outXfer)      mainClear = 1'b1;
                end
                ST_FULL2: begin
                    // in_ready is low here, so only the output side can move.
                    if (outXfer) begin
                        mainLoad     = 1'b1;
                        mainFromSkid = 1'b1;
                        skidClear    = 1'b1;
                    end
                end
                default: ; // {0,1} is unreachable
            endcase
        end
    end

    assign mainLdCtrl = mainFromSkid ? skidCtrl : in_ctrl;
    assign mainLdData = mainFromSkid ? skidData : in_data;

    pipe_skid_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CTRL_BUBBLE(CTRL_BUBBLE)) uMain (
        .clk(clk), .reset(reset), .clear(mainClear), .load(mainLoad),
        .ldCtrl(mainLdCtrl), .ldData(mainLdData),
        .valid(mainValid), .ctrl(mainCtrl), .data(mainData)
    );

    pipe_skid_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CTRL_BUBBLE(CTRL_BUBBLE)) uSkid (
        .clk(clk), .reset(reset), .clear(skidClear), .load(skidLoad),
        .ldCtrl(in_ctrl), .ldData(in_data),
        .valid(skidValid), .ctrl(skidCtrl), .data(skidData)
    );

    // Outputs: straight from the slot flops.
    always_comb begin
        in_ready  = !skidValid;
        out_valid = mainValid;
        out_ctrl  = mainCtrl;
        out_data  = mainData;
        dbgState  = {mainValid, skidValid};
    end

`ifdef PIPE_STAGE_BUF_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (mainValid && !out_ready && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + 1'b1;
            if (flush && (flush_cnt != {CNT_W{1'b1}}))
                flush_cnt <= flush_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
module tb_pipe_stage_buf;

    localparam int DW = 96;
    localparam int CW = 9;
    localparam logic [CW-1:0] BUBBLE = 9'h000;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [CW-1:0] in_ctrl = '0;
    logic [DW-1:0] in_data = '0;
    logic          flush = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
    logic [1:0]    dbgState;
`ifdef PIPE_STAGE_BUF_PERF_EN
    logic [1:0]    stall_cnt;
    logic [1:0]    flush_cnt;
`endif

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] expQ[$];   // model: beats held by the stage, oldest first
    logic [DW-1:0] outLog[$]; // data actually handed downstream

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    pipe_stage_buf #(
        .DATA_W(DW), .CTRL_W(CW), .CTRL_BUBBLE(BUBBLE)
`ifdef PIPE_STAGE_BUF_PERF_EN
        , .CNT_W(2)
`endif
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ctrl(out_ctrl), .out_data(out_data),
        .dbgState(dbgState)
`ifdef PIPE_STAGE_BUF_PERF_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    function automatic logic [CW-1:0] ctrlOf(input logic [DW-1:0] d);
        return {d[7:0], 1'b1};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver ----------------
    // Applies inputs 1 time unit after a rising edge and returns just after the
    // edge that consumed them.
    task automatic drive(input logic v, input logic [DW-1:0] d, input logic r, input logic f);
        in_valid  = v;
        in_data   = d;
        in_ctrl   = ctrlOf(d);
        out_ready = r;
        flush     = f;
        @(posedge clk);
        #1;
    endtask

    // ---------------- model: a FIFO of at most two beats ----------------
    always @(posedge clk) begin
        logic pushOk;
        if (!reset || flush) begin
            expQ.delete();
        end else begin
            pushOk = in_valid && (expQ.size() < 2);
            if ((expQ.size() > 0) && out_ready) void'(expQ.pop_front());
            if (pushOk) expQ.push_back(in_data);
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (reset) begin
            chk("cyc_out_valid", 128'(out_valid), 128'(expQ.size() > 0));
            chk("cyc_in_ready", 128'(in_ready), 128'(expQ.size() < 2));
            chk("cyc_state", 128'(dbgState), 128'({expQ.size() > 0, expQ.size() > 1}));
            chk("cyc_no_01_state", 128'(dbgState == 2'b01), 128'(0));
            if (expQ.size() > 0) begin
                chk("cyc_out_ctrl", 128'(out_ctrl), 128'(ctrlOf(expQ[0])));
                chk("cyc_out_data", 128'(out_data), 128'(expQ[0]));
            end else begin
                chk("cyc_bubble_ctrl", 128'(out_ctrl), 128'(BUBBLE));
            end
            if (out_valid && out_ready) outLog.push_back(out_data);
        end
    end

    // ---------------- directed tests ----------------
    initial begin
        logic seen66;

        // reset state
        #1;
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        chk("rst_out_ctrl", 128'(out_ctrl), 128'(BUBBLE));
        chk("rst_out_data", 128'(out_data), 128'(0));
        @(posedge clk);
        #1;
        reset = 1'b1;

`ifdef PIPE_STAGE_BUF_PERF_EN
        // stall counter saturates at 3 with CNT_W=2
        drive(1'b1, 96'h99, 1'b0, 1'b0);
        drive(1'b0, 96'h0, 1'b0, 1'b0); chk("stall_cnt_1", 128'(stall_cnt), 128'(1));
        drive(1'b0, 96'h0, 1'b0, 1'b0); chk("stall_cnt_2", 128'(stall_cnt), 128'(2));
        drive(1'b0, 96'h0, 1'b0, 1'b0); chk("stall_cnt_3", 128'(stall_cnt), 128'(3));
        drive(1'b0, 96'h0, 1'b0, 1'b0); chk("stall_cnt_4", 128'(stall_cnt), 128'(3));
        drive(1'b0, 96'h0, 1'b0, 1'b0); chk("stall_cnt_5", 128'(stall_cnt), 128'(3));
        drive(1'b0, 96'h0, 1'b0, 1'b1); chk("flush_cnt_1", 128'(flush_cnt), 128'(1));
        drive(1'b0, 96'h0, 1'b1, 1'b0);
`endif

        // stream 1..8 at full rate
        outLog.delete();
        for (int k = 1; k <= 8; k++) begin
            drive(1'b1, DW'(k), 1'b1, 1'b0);
            chk("stream_valid", 128'(out_valid), 128'(1));
            chk("stream_data", 128'(out_data), 128'(k));
            chk("stream_in_ready", 128'(in_ready), 128'(1));
        end
        drive(1'b0, 96'h0, 1'b1, 1'b0);
        drive(1'b0, 96'h0, 1'b1, 1'b0);
        chk("stream_count", 128'(outLog.size()), 128'(8));
        for (int k = 0; k < 8 && k < outLog.size(); k++)
            chk("stream_order", 128'(outLog[k]), 128'(k + 1));

        // stall: A in main, B into skid, C held upstream
        outLog.delete();
        drive(1'b1, 96'h11, 1'b0, 1'b0);
        drive(1'b1, 96'h22, 1'b0, 1'b0);
        chk("stall_in_ready_drop", 128'(in_ready), 128'(0));
        drive(1'b1, 96'h33, 1'b0, 1'b0);
        drive(1'b1, 96'h33, 1'b0, 1'b0);
        chk("stall_hold_data", 128'(out_data), 128'(96'h11));
        chk("stall_hold_ready", 128'(in_ready), 128'(0));
        drive(1'b1, 96'h33, 1'b1, 1'b0);
        chk("stall_rel_1", 128'(out_data), 128'(96'h22));
        drive(1'b1, 96'h33, 1'b1, 1'b0);
        chk("stall_rel_2", 128'(out_data), 128'(96'h33));
        drive(1'b0, 96'h0, 1'b1, 1'b0);
        chk("stall_log_n", 128'(outLog.size()), 128'(3));
        if (outLog.size() == 3) begin
            chk("stall_log_0", 128'(outLog[0]), 128'(96'h11));
            chk("stall_log_1", 128'(outLog[1]), 128'(96'h22));
            chk("stall_log_2", 128'(outLog[2]), 128'(96'h33));
        end

        // flush from FULL2 with a beat offered in the same cycle
        outLog.delete();
        drive(1'b1, 96'h44, 1'b0, 1'b0);
        drive(1'b1, 96'h55, 1'b0, 1'b0);
        chk("full2_in_ready", 128'(in_ready), 128'(0));
        drive(1'b1, 96'h66, 1'b0, 1'b1);
        chk("flush_valid", 128'(out_valid), 128'(0));
        chk("flush_ctrl", 128'(out_ctrl), 128'(BUBBLE));
        chk("flush_in_ready", 128'(in_ready), 128'(1));
        drive(1'b0, 96'h0, 1'b1, 1'b0);
        drive(1'b0, 96'h0, 1'b1, 1'b0);
        seen66 = 1'b0;
        foreach (outLog[i]) if (outLog[i] == 96'h66) seen66 = 1'b1;
        chk("flush_no_66", 128'(seen66), 128'(0));
        chk("flush_log_empty", 128'(outLog.size()), 128'(0));

        // flush coinciding with an output transfer
        outLog.delete();
        drive(1'b1, 96'h77, 1'b1, 1'b0);
        drive(1'b0, 96'h0, 1'b1, 1'b1);
        chk("flush_xfer_n", 128'(outLog.size()), 128'(1));
        if (outLog.size() == 1) chk("flush_xfer_data", 128'(outLog[0]), 128'(96'h77));
        chk("flush_xfer_empty", 128'(dbgState), 128'(2'b00));

        // asynchronous reset while FULL2
        drive(1'b1, 96'hA1, 1'b0, 1'b0);
        drive(1'b1, 96'hA2, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("arst_out_valid", 128'(out_valid), 128'(0));
        chk("arst_in_ready", 128'(in_ready), 128'(1));
        chk("arst_out_ctrl", 128'(out_ctrl), 128'(BUBBLE));
        @(posedge clk);
        #1;
        reset = 1'b1;
        drive(1'b1, 96'hB1, 1'b1, 1'b0);
        chk("post_rst_data", 128'(out_data), 128'(96'hB1));
        drive(1'b0, 96'h0, 1'b1, 1'b0);
        drive(1'b0, 96'h0, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
